// File: rtl/seg_readback.sv
// rtl/seg_readback.sv - recovers hex digits from a multiplexed active-low seven-segment bus
//
// Purpose: watches the dual-digit display bus, waits for each segment/anode
// pattern to sit still for STABLE_CYCLES cycles, then maps the pattern back to
// its 4-bit value. Blank patterns clear the digit's valid flag; patterns the
// display decoder cannot produce raise err and bump a saturating counter.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   seg_in[6:0]       segment lines, active-low, bit 6 = a .. bit 0 = g
//   an_in[1:0]        digit enables, active-low (2'b10 = digit 0, 2'b01 = digit 1)
//   digit0/digit1     last legal value recovered for each digit
//   valid0/valid1     digit holds a value from a legal, non-blank capture
//   upd               one-cycle pulse on every capture
//   err               one-cycle pulse on an illegal capture
//   err_count[7:0]    illegal capture count, saturating at 255
module seg_readback #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg_in,
  input  logic [1:0] an_in,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic       valid0,
  output logic       valid1,
  output logic       upd,
  output logic       err,
  output logic [7:0] err_count
);

  localparam logic [7:0] CNT_MAX  = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [1:0] AN_NONE   = 2'b11;

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;

  // Returns {legal, value}; blank is handled by the caller.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'b0000001: r = {1'b1, 4'h0};
      7'b1001111: r = {1'b1, 4'h1};
      7'b0010010: r = {1'b1, 4'h2};
      7'b0000110: r = {1'b1, 4'h3};
      7'b1001100: r = {1'b1, 4'h4};
      7'b0100100: r = {1'b1, 4'h5};
      7'b0100000: r = {1'b1, 4'h6};
      7'b0001110: r = {1'b1, 4'h7};
      7'b0000000: r = {1'b1, 4'h8};
      7'b0001100: r = {1'b1, 4'h9};
      7'b0001000: r = {1'b1, 4'hA};
      7'b1100000: r = {1'b1, 4'hB};
      7'b0110001: r = {1'b1, 4'hC};
      7'b1000010: r = {1'b1, 4'hD};
      7'b0110000: r = {1'b1, 4'hE};
      7'b0111000: r = {1'b1, 4'hF};
      default:    r = 5'b0_0000;
    endcase
    return r;
  endfunction

  state_t     state_q, state_d;
  logic [8:0] s_q, s_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] digit0_q, digit0_d, digit1_q, digit1_d;
  logic       valid0_q, valid0_d, valid1_q, valid1_d;
  logic       upd_q, upd_d, err_q, err_d;
  logic [7:0] err_count_q, err_count_d;

  logic       same;
  logic       capture;
  logic [4:0] dec;

  always_comb begin
    s_d         = {an_in, seg_in};
    same        = (s_d == s_q);
    cnt_d       = 8'd0;
    state_d     = state_q;
    digit0_d    = digit0_q;
    digit1_d    = digit1_q;
    valid0_d    = valid0_q;
    valid1_d    = valid1_q;
    upd_d       = 1'b0;
    err_d       = 1'b0;
    err_count_d = err_count_q;
    dec         = decode(seg_in);

    if (same) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1;
    end

    // The capture decision is taken on the last stable cycle of the window so
    // the registered results appear while the FSM sits in CAPTURE.
    capture = ((state_q == IDLE) || (state_q == SETTLE)) && (an_in != AN_NONE)
              && same && (cnt_d == CNT_LAST);

    case (state_q)
      IDLE, SETTLE: begin
        if (an_in == AN_NONE) state_d = IDLE;
        else if (capture)     state_d = CAPTURE;
        else                  state_d = SETTLE;
      end
      default: begin
        // A change arriving during CAPTURE is treated like one during HOLD so
        // the new window is not lost.
        if (!same) state_d = (an_in == AN_NONE) ? IDLE : SETTLE;
        else       state_d = HOLD;
      end
    endcase

    if (capture) begin
      upd_d = 1'b1;
      if (an_in == 2'b00) begin
        valid0_d = 1'b0;
        valid1_d = 1'b0;
        err_d    = 1'b1;
      end else if (an_in == 2'b10) begin
        if (seg_in == SEG_BLANK) begin
          valid0_d = 1'b0;
        end else if (dec[4]) begin
          digit0_d = dec[3:0];
          valid0_d = 1'b1;
        end else begin
          valid0_d = 1'b0;
          err_d    = 1'b1;
        end
      end else begin
        if (seg_in == SEG_BLANK) begin
          valid1_d = 1'b0;
        end else if (dec[4]) begin
          digit1_d = dec[3:0];
          valid1_d = 1'b1;
        end else begin
          valid1_d = 1'b0;
          err_d    = 1'b1;
        end
      end
    end

    if (err_d && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      s_q         <= {AN_NONE, SEG_BLANK};
      cnt_q       <= 8'd0;
      digit0_q    <= 4'd0;
      digit1_q    <= 4'd0;
      valid0_q    <= 1'b0;
      valid1_q    <= 1'b0;
      upd_q       <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      cnt_q       <= cnt_d;
      digit0_q    <= digit0_d;
      digit1_q    <= digit1_d;
      valid0_q    <= valid0_d;
      valid1_q    <= valid1_d;
      upd_q       <= upd_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign digit0    = digit0_q;
  assign digit1    = digit1_q;
  assign valid0    = valid0_q;
  assign valid1    = valid1_q;
  assign upd       = upd_q;
  assign err       = err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_seg_readback.sv
// tb/tb_seg_readback.sv - directed self-checking bench for seg_readback
module tb_seg_readback;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] seg_in = 7'h7F;
  logic [1:0] an_in = 2'b11;
  logic [3:0] digit0, digit1;
  logic       valid0, valid1, upd, err;
  logic [7:0] err_count;

  int total = 0;
  int bad = 0;
  int upd_cnt = 0;
  int upd_base;

  seg_readback #(.STABLE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .seg_in(seg_in), .an_in(an_in),
    .digit0(digit0), .digit1(digit1), .valid0(valid0), .valid1(valid1),
    .upd(upd), .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (upd === 1'b1) upd_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n clock edges, landing 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] an, input logic [6:0] seg);
    an_in  = an;
    seg_in = seg;
  endtask

  initial begin
    // Reset with arbitrary inputs
    drive(2'b00, 7'h2A);
    tick(2);
    chk("rst_digit0", digit0, 0);
    chk("rst_digit1", digit1, 0);
    chk("rst_valid", {valid0, valid1}, 0);
    chk("rst_upd_err", {upd, err}, 0);
    chk("rst_err_count", err_count, 0);
    drive(2'b11, 7'h7F);
    reset = 1'b0;
    upd_base = upd_cnt;
    tick(5);
    chk("idle_no_upd", upd_cnt - upd_base, 0);

    // Legal capture of 5 on digit 0; latency exactly 4 cycles
    upd_base = upd_cnt;
    drive(2'b10, 7'b0100100);
    tick(3);
    chk("legal_early_upd", upd, 0);
    tick(1);
    chk("legal_upd", upd, 1);
    chk("legal_digit0", digit0, 5);
    chk("legal_valid0", valid0, 1);
    chk("legal_err", err, 0);
    tick(20);
    chk("legal_one_upd", upd_cnt - upd_base, 1);

    // Multiplex A on digit 0, d on digit 1 with blanking gaps
    upd_base = upd_cnt;
    drive(2'b11, 7'h7F); tick(1);
    drive(2'b10, 7'b0001000); tick(6);
    drive(2'b11, 7'h7F); tick(1);
    drive(2'b01, 7'b1000010); tick(6);
    drive(2'b11, 7'h7F); tick(1);
    chk("mux_digit0", digit0, 4'hA);
    chk("mux_digit1", digit1, 4'hD);
    chk("mux_valids", {valid0, valid1}, 2'b11);
    chk("mux_upd_count", upd_cnt - upd_base, 2);

    // Glitch rejection: 3 cycles of 3, one cycle of 8, then 3 held
    upd_base = upd_cnt;
    drive(2'b10, 7'b0000110); tick(3);
    drive(2'b10, 7'b0000000); tick(1);
    drive(2'b10, 7'b0000110); tick(3);
    chk("glitch_no_upd", upd_cnt - upd_base, 0);
    chk("glitch_digit0_keep", digit0, 4'hA);
    tick(1);
    chk("glitch_upd", upd, 1);
    chk("glitch_digit0", digit0, 3);
    tick(2);
    chk("glitch_one_upd", upd_cnt - upd_base, 1);

    // Illegal pattern on digit 1
    drive(2'b11, 7'h7F); tick(1);
    drive(2'b01, 7'b1010101); tick(4);
    chk("ill_upd_err", {upd, err}, 2'b11);
    chk("ill_valid1", valid1, 0);
    chk("ill_digit1", digit1, 4'hD);
    chk("ill_valid0", valid0, 1);
    chk("ill_err_count", err_count, 1);
    tick(1);
    chk("ill_err_pulse", err, 0);

    // Both anodes on
    drive(2'b00, 7'b0000001); tick(4);
    chk("both_err", err, 1);
    chk("both_valids", {valid0, valid1}, 0);
    chk("both_err_count", err_count, 2);
    tick(1);

    // 260 more illegal captures -> saturation
    upd_base = upd_cnt;
    for (int i = 0; i < 260; i++) begin
      drive((i % 2 == 0) ? 2'b10 : 2'b01, 7'b1010101);
      tick(5);
    end
    chk("sat_err_count", err_count, 255);
    chk("sat_upd_count", upd_cnt - upd_base, 260);

    // Blank after a legal 7 on digit 0
    drive(2'b10, 7'b0001110); tick(5);
    chk("blank_pre_digit0", digit0, 7);
    chk("blank_pre_valid0", valid0, 1);
    drive(2'b10, 7'h7F); tick(4);
    chk("blank_upd", upd, 1);
    chk("blank_err", err, 0);
    chk("blank_valid0", valid0, 0);
    chk("blank_digit0", digit0, 7);
    chk("blank_err_count", err_count, 255);
    tick(1);

    // Reset mid-window aborts it; a full window is needed afterwards
    drive(2'b01, 7'b1001111); tick(2);
    reset = 1'b1; tick(1);
    chk("rst2_err_count", err_count, 0);
    chk("rst2_digit0", digit0, 0);
    reset = 1'b0;
    upd_base = upd_cnt;
    tick(3);
    chk("rst2_no_upd", upd_cnt - upd_base, 0);
    tick(1);
    chk("rst2_upd", upd, 1);
    chk("rst2_digit1", digit1, 1);
    chk("rst2_valid1", valid1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
